// File: rtl/dp_sqrt_prenorm_if.sv
// Operand/result bundle for dp_sqrt_prenorm.
// master: operand source / result sink (upstream logic and core side).
// slave : the prenormalisation stage itself.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. A source holds valid and its payload until that edge and never
// waits for ready before raising valid.
interface dp_sqrt_prenorm_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] x;
    logic        out_valid;
    logic        out_ready;
    logic [53:0] ix;
    logic [10:0] y_exponent;
    logic        y_sign;
    logic [1:0]  y_class;
    logic [1:0]  dbg_state;

    modport master (
        output in_valid, x, out_ready,
        input  in_ready, out_valid, ix, y_exponent, y_sign, y_class, dbg_state
    );

    modport slave (
        input  in_valid, x, out_ready,
        output in_ready, out_valid, ix, y_exponent, y_sign, y_class, dbg_state
    );
endinterface

// File: rtl/dp_sqrt_prenorm.sv
// dp_sqrt_prenorm: input stage ahead of the binary64 square-root core.
// Classifies the operand, normalises subnormals with a multi-cycle left
// shifter, and hands the core a parity-aligned radicand, the halved biased
// exponent, the sign and a special-case class. One operand in flight.
// Build option: define DP_SQRT_PRENORM_DAZ_EN to flush subnormals to zero;
// the NORM state and shifter then disappear and every operand takes one edge.
// SHIFT_STEP (1, 2, 4 or 8) is the coarse shift used while the top
// SHIFT_STEP significand bits are all zero.
module dp_sqrt_prenorm #(
    parameter int SHIFT_STEP = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    dp_sqrt_prenorm_if.slave   bus,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [1:0] CLS_FIN  = 2'd0;
    localparam logic [1:0] CLS_ZERO = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;

    state_t      state, state_nxt;
    logic [53:0] ix_q, ix_nxt;
    logic [10:0] yexp_q, yexp_nxt;
    logic        ysign_q, ysign_nxt;
    logic [1:0]  ycls_q, ycls_nxt;

    logic        accept;
    logic        x_sign;
    logic [10:0] x_exp;
    logic [51:0] x_frac;

`ifdef DP_SQRT_PRENORM_DAZ_EN
    // Subnormals are flushed at decode; no shifter state is kept.
`else
    localparam logic signed [12:0] STEP_E = 13'(SHIFT_STEP);

    logic [52:0]        sig_q, sig_nxt, sig_shift;
    logic signed [12:0] eeff_q, eeff_nxt, eeff_shift;
`endif

    // Halved biased exponent; e_eff+1023 is always positive for finite inputs
    // that reach here, so the 11-bit result never wraps.
    function automatic logic [10:0] half_exp(input logic signed [12:0] ee);
        logic signed [12:0] biased;
        biased = ee + 13'sd1023;
        return 11'(biased >>> 1);
    endfunction

    // Radicand alignment: an odd exponent keeps the significand as is, an even
    // one moves it up a bit so the core always sees an even-exponent radicand.
    function automatic logic [53:0] align_sig(input logic [52:0] sig, input logic odd);
        return odd ? {1'b0, sig} : {sig, 1'b0};
    endfunction

    assign x_sign = bus.x[63];
    assign x_exp  = bus.x[62:52];
    assign x_frac = bus.x[51:0];

    assign bus.in_ready   = (state == IDLE) | ((state == OUT) & bus.out_ready);
    assign accept         = bus.in_valid & bus.in_ready;
    assign bus.out_valid  = (state == OUT);
    assign bus.ix         = ix_q;
    assign bus.y_exponent = yexp_q;
    assign bus.y_sign     = ysign_q;
    assign bus.y_class    = ycls_q;
    assign bus.dbg_state  = state;
    assign busy           = (state != IDLE);

    // Next-state, operand decode and normalisation step.
    always_comb begin
        state_nxt = state;
        ix_nxt    = ix_q;
        yexp_nxt  = yexp_q;
        ysign_nxt = ysign_q;
        ycls_nxt  = ycls_q;
`ifdef DP_SQRT_PRENORM_DAZ_EN
`else
        sig_nxt    = sig_q;
        eeff_nxt   = eeff_q;
        sig_shift  = sig_q;
        eeff_shift = eeff_q;
`endif

        case (state)
            IDLE, OUT: begin
                if (accept) begin
                    state_nxt = OUT;
                    ix_nxt    = '0;
                    ysign_nxt = 1'b0;
                    if ((x_exp == 11'd0) && (x_frac == 52'd0)) begin
                        ycls_nxt  = CLS_ZERO;
                        yexp_nxt  = 11'd0;
                        ysign_nxt = x_sign;
                    end else if ((x_exp == 11'h7FF) && (x_frac == 52'd0) && !x_sign) begin
                        ycls_nxt = CLS_INF;
                        yexp_nxt = 11'h7FF;
                    end else if ((x_exp == 11'h7FF) || x_sign) begin
                        // NaN input, or any negative nonzero value including -inf.
                        ycls_nxt = CLS_NAN;
                        yexp_nxt = 11'h7FF;
                    end else if (x_exp != 11'd0) begin
                        ycls_nxt = CLS_FIN;
                        ix_nxt   = align_sig({1'b1, x_frac}, x_exp[0]);
                        yexp_nxt = half_exp($signed({2'b00, x_exp}));
                    end else begin
`ifdef DP_SQRT_PRENORM_DAZ_EN
                        ycls_nxt  = CLS_ZERO;
                        yexp_nxt  = 11'd0;
                        ysign_nxt = x_sign;
`else
                        // Subnormal: park the significand in the shifter.
                        state_nxt = NORM;
                        sig_nxt   = {1'b0, x_frac};
                        eeff_nxt  = 13'sd1;
`endif
                    end
                end else if ((state == OUT) && bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
`ifdef DP_SQRT_PRENORM_DAZ_EN
`else
            NORM: begin
                if (sig_q[52 -: SHIFT_STEP] == '0) begin
                    sig_shift  = sig_q << SHIFT_STEP;
                    eeff_shift = eeff_q - STEP_E;
                end else begin
                    sig_shift  = sig_q << 1;
                    eeff_shift = eeff_q - 13'sd1;
                end
                sig_nxt  = sig_shift;
                eeff_nxt = eeff_shift;
                if (sig_shift[52]) begin
                    state_nxt = OUT;
                    ycls_nxt  = CLS_FIN;
                    ysign_nxt = 1'b0;
                    ix_nxt    = align_sig(sig_shift, eeff_shift[0]);
                    yexp_nxt  = half_exp(eeff_shift);
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and result registers; reset drops any operand in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ix_q    <= '0;
            yexp_q  <= '0;
            ysign_q <= 1'b0;
            ycls_q  <= '0;
        end else begin
            state   <= state_nxt;
            ix_q    <= ix_nxt;
            yexp_q  <= yexp_nxt;
            ysign_q <= ysign_nxt;
            ycls_q  <= ycls_nxt;
        end
    end

`ifdef DP_SQRT_PRENORM_DAZ_EN
`else
    // Normaliser registers: significand being shifted and its exponent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q  <= '0;
            eeff_q <= '0;
        end else begin
            sig_q  <= sig_nxt;
            eeff_q <= eeff_nxt;
        end
    end
`endif

endmodule
